// File: rtl/impl_equiv_checker.sv
// Drives one stimulus vector to several implementations of the same function and
// flags any vector whose outputs disagree; one vector every SETTLE cycles.
module impl_equiv_checker #(
  parameter int WIDTH    = 6,
  parameter int NUM_IMPL = 3,
  parameter int SETTLE   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [NUM_IMPL-1:0] impl_out,
  output logic [WIDTH-1:0]    vec_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [WIDTH:0]      mismatch_count,
  output logic [WIDTH-1:0]    first_fail_vec,
  output logic                first_fail_valid
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

  function automatic logic [WIDTH-1:0] alt_pat();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = ((i % 2) == 0);
    return r;
  endfunction

  localparam logic [WIDTH-1:0] ALT = alt_pat();

  // Directed mode reuses the low two index bits to select one of four patterns.
  function automatic logic [WIDTH-1:0] pattern(input logic m, input logic [WIDTH-1:0] idx);
    logic [WIDTH-1:0] r;
    r = idx;
    if (m) begin
      case (idx[1:0])
        2'd0:    r = '0;
        2'd1:    r = '1;
        2'd2:    r = ALT;
        default: r = ~ALT;
      endcase
    end
    return r;
  endfunction

  state_t           state_q;
  logic             mode_q;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [7:0]       cnt_q;
  logic [WIDTH:0]   mm_q, mm_d;
  logic [WIDTH-1:0] ffv_q;
  logic             ffval_q;
  logic             busy_q, done_q, pass_q;
  logic             mismatch, last;

  always_comb begin
    mismatch = (|impl_out) && !(&impl_out);
    last     = mode_q ? (idx_q == WIDTH'(3)) : (&idx_q);
    idx_d    = idx_q + WIDTH'(1);
    vec_d    = pattern(mode_q, idx_d);
    mm_d     = mm_q + (mismatch ? (WIDTH+1)'(1) : (WIDTH+1)'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      mm_q    <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= HOLD;
            mode_q  <= mode;
            idx_q   <= '0;
            vec_q   <= pattern(mode, '0);
            cnt_q   <= '0;
            mm_q    <= '0;
            ffv_q   <= '0;
            ffval_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (mismatch) begin
              mm_q <= mm_d;
              if (!ffval_q) begin
                ffv_q   <= vec_q;
                ffval_q <= 1'b1;
              end
            end
            if (last) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mm_d == '0);
            end else begin
              idx_q <= idx_d;
              vec_q <= vec_d;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out          = vec_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffval_q;

endmodule

// File: doc/impl_equiv_checker.md
# impl_equiv_checker

Self-checking stimulus engine that replaces hand-written vector lists for comparing several implementations of the same combinational function. The implementations are typically the dataflow, behavioral and gate versions. It drives a WIDTH-bit input vector onto all implementations in parallel and waits a programmable settle time. It then checks that every implementation output agrees, and accumulates a mismatch count and the first failing vector. It sits beside the DUT instances in the module's test harness and runs from one clock.

## Interface
Parameters:
- WIDTH, default 6: input vector width shared by all implementations (2..16).
- NUM_IMPL, default 3: number of implementation outputs compared (1..8).
- SETTLE, default 2: cycles a vector is held before its outputs are sampled (1..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run when the block is not busy.
- mode  input  1  0 = exhaustive sweep; 1 = directed four-pattern set. Sampled only on an accepted start.
- impl_out  input  NUM_IMPL  bit i is the output of implementation i for the current vec_out.
- vec_out  output  WIDTH  stimulus vector driven to all implementations.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  done && mismatch_count == 0.
- mismatch_count  output  WIDTH+1  number of vectors whose outputs disagreed.
- first_fail_vec  output  WIDTH  first vector that disagreed; valid when first_fail_valid is high.
- first_fail_valid  output  1  at least one mismatch occurred this run.

## Operation
- States: IDLE, HOLD, DONE.
- IDLE:
  - A start pulse clears mismatch_count, first_fail_valid and first_fail_vec, and latches mode.
  - vec_out is loaded with pattern 0 and the block moves to HOLD.
- HOLD:
  - The settle counter runs 0..SETTLE-1.
  - Sampling happens in the cycle where the counter equals SETTLE-1.
  - Mismatch rule: impl_out is neither all-zeros nor all-ones. For NUM_IMPL = 1 a mismatch never occurs.
  - On a mismatch, mismatch_count increments. If first_fail_valid is low, first_fail_vec takes vec_out and first_fail_valid is set.
  - In the same cycle, either vec_out advances to the next pattern and the counter restarts, or, if this was the last pattern, the block moves to DONE.
- Patterns, mode 0: 0, 1, …, 2^WIDTH−1 ascending; N = 2^WIDTH. The last pattern is all-ones, so the sequence has no wrap-around.
- Patterns, mode 1: N = 4, in this order:
  - all-zeros;
  - all-ones;
  - alternating with LSB = 1 (6'b010101 at WIDTH = 6);
  - its complement (6'b101010).
- DONE:
  - vec_out holds the last pattern and the results hold.
  - A start pulse starts a new run exactly as from IDLE.
- start while in HOLD is ignored, with no effect on the sequence or counters.
- mismatch_count is WIDTH+1 bits and cannot overflow, since its maximum is 2^WIDTH.

## Timing
- Reset values: vec_out = 0, busy = 0, done = 0, pass = 0, mismatch_count = 0, first_fail_vec = 0, first_fail_valid = 0; state = IDLE.
- Start is accepted at edge T0.
  - busy rises and vec_out = pattern 0 from T0.
  - Each pattern is held exactly SETTLE cycles.
  - impl_out is sampled at the last edge of each hold window, i.e. SETTLE−1 cycles after the vector changed.
- done and pass rise, and busy falls, at edge T0 + N·SETTLE.
- Results of the final sample are visible in the same cycle that done rises.
- busy and done are never high together.
- Reset mid-run returns the block immediately and asynchronously to IDLE with all outputs at their reset values; the partial results are discarded.
- impl_out must be stable within SETTLE−1 cycles of a vector change. This is the user's constraint and is not checked by the block.

## Test plan
- **Clean exhaustive run:** defaults; mode 0; all impl_out equal to a 6-input AND of vec_out; start pulse. Required: done at T0+128, pass = 1, mismatch_count = 0, first_fail_valid = 0, and vec_out visits 0x00..0x3F in order.
- **Injected fault:** defaults; impl_out[2] inverted only when vec_out = 6'h2A. Required: mismatch_count = 1, first_fail_vec = 6'h2A, first_fail_valid = 1, pass = 0.
- **Directed mode:** mode 1; SETTLE = 3. Required: vec_out sequence 00, 3F, 15, 2A, each held 3 cycles; done at T0+12.
- **Multiple faults:** all impl_out differ on vectors 0x05 and 0x30. Required: mismatch_count = 2, first_fail_vec = 0x05.
- **Start while busy:** start pulse at T0+10 during a mode-0 run. Required: the sequence is unaffected and done still rises at T0+128. A start in DONE then clears the counters and restarts from 0x00.
- **Reset mid-run:** rst asserted at T0+50, asynchronously and between edges. Required: all outputs go to zero immediately. After release a new start runs to completion with correct results.
